// File: rtl/prefetch_queue_ctrl.sv
// rtl/prefetch_queue_ctrl.sv - 8086 instruction prefetch queue and ROM fetch sequencer
module prefetch_queue_ctrl #(
  parameter int          DEPTH    = 6,
  parameter int          ADDR_W   = 20,
  parameter logic [15:0] RESET_CS = 16'hFFFF,
  parameter logic [15:0] RESET_IP = 16'h0000
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  input  logic [15:0]                          flush_cs,
  input  logic [15:0]                          flush_ip,
  input  logic [1:0]                           consume,
  output logic                                 rom_en,
  output logic [ADDR_W-1:0]                    rom_addr,
  input  logic [7:0]                           rom_data,
  output logic [((DEPTH > 7) ? 4 : 3)-1:0]     q_count,
  output logic [15:0]                          q_data,
  output logic [15:0]                          head_ip,
  output logic                                 consume_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int QW    = (DEPTH > 7) ? 4 : 3;

  // Circular byte storage; only the slots between head and head+count are meaningful.
  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [3:0]       count;
  logic             inflight;
  logic [15:0]      cs;
  logic [15:0]      fetch_ip;

  logic [1:0]       cons_req;
  logic             cons_bad;
  logic [1:0]       take;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] head_p1;

  // Pointer addition modulo DEPTH; both operands are below DEPTH+1 so one fold suffices.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] base,
                                               input logic [3:0]       n);
    logic [4:0] sum;
    sum = 5'(base) + 5'(n);
    if (sum >= 5'(DEPTH)) begin
      sum = sum - 5'(DEPTH);
    end
    return PTR_W'(sum);
  endfunction

  // Consume legality is judged against the count held before this cycle's fill.
  always_comb begin
    cons_req = (consume == 2'd3) ? 2'd0 : consume;
    cons_bad = (4'(cons_req) > count);
    take     = cons_bad ? 2'd0 : cons_req;
    tail     = ptr_add(head, count);
    head_p1  = ptr_add(head, 4'd1);
  end

  // Issue only when the returning byte is guaranteed a slot even if nothing is consumed.
  always_comb begin
    rom_en   = !rst && !flush && ((count + 4'(inflight)) < 4'(DEPTH));
    rom_addr = ADDR_W'({cs, 4'b0000}) + ADDR_W'(fetch_ip);
  end

  // Head bytes are masked to zero when the queue holds fewer than two bytes.
  always_comb begin
    q_data[7:0]  = (count != 4'd0) ? mem[head]    : 8'h00;
    q_data[15:8] = (count >= 4'd2) ? mem[head_p1] : 8'h00;
    q_count      = QW'(count);
  end

  // Returning ROM byte lands at the tail; a flush or reset drops it.
  always_ff @(posedge clk) begin
    if (!rst && !flush && inflight) begin
      mem[tail] <= rom_data;
    end
  end

  // Queue bookkeeping, fetch pointer and segment registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head        <= '0;
      count       <= 4'd0;
      inflight    <= 1'b0;
      cs          <= RESET_CS;
      fetch_ip    <= RESET_IP;
      head_ip     <= RESET_IP;
      consume_err <= 1'b0;
    end else if (flush) begin
      head        <= '0;
      count       <= 4'd0;
      inflight    <= 1'b0;
      cs          <= flush_cs;
      fetch_ip    <= flush_ip;
      head_ip     <= flush_ip;
      consume_err <= 1'b0;
    end else begin
      inflight    <= rom_en;
      if (rom_en) begin
        fetch_ip <= fetch_ip + 16'd1;
      end
      count       <= count - 4'(take) + 4'(inflight);
      head        <= ptr_add(head, 4'(take));
      head_ip     <= head_ip + 16'(take);
      consume_err <= cons_bad;
    end
  end

endmodule

// File: tb/tb_prefetch_queue_ctrl.sv
// tb/tb_prefetch_queue_ctrl.sv - directed vector bench for prefetch_queue_ctrl
module tb_prefetch_queue_ctrl;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [15:0] flush_cs;
  logic [15:0] flush_ip;
  logic [1:0]  consume;
  logic        rom_en;
  logic [19:0] rom_addr;
  logic [7:0]  rom_data;
  logic [2:0]  q_count;
  logic [15:0] q_data;
  logic [15:0] head_ip;
  logic        consume_err;

  int n_checks;
  int n_fail;

  typedef struct {
    logic        rst;
    logic        flush;
    logic [15:0] fcs;
    logic [15:0] fip;
    logic [1:0]  cons;
    logic        en;
    logic [19:0] addr;
    logic [2:0]  qc;
    logic [15:0] qd;
    logic [15:0] hip;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  prefetch_queue_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .flush_cs    (flush_cs),
    .flush_ip    (flush_ip),
    .consume     (consume),
    .rom_en      (rom_en),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .q_count     (q_count),
    .q_data      (q_data),
    .head_ip     (head_ip),
    .consume_err (consume_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: byte value is the low address byte, one cycle after the strobe.
  always @(posedge clk) begin
    rom_data <= rom_en ? rom_addr[7:0] : 8'hEE;
  end

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic f, input logic [15:0] c,
                     input logic [15:0] ip, input logic [1:0] k);
    @(negedge clk);
    rst      = r;
    flush    = f;
    flush_cs = c;
    flush_ip = ip;
    consume  = k;
    #1;
  endtask

  task automatic add(input logic r, input logic [1:0] k, input logic en,
                     input logic [19:0] addr, input logic [2:0] qc,
                     input logic [15:0] qd, input logic [15:0] hip, input logic err);
    vec_t v;
    v.rst = r; v.flush = 1'b0; v.fcs = 16'h0; v.fip = 16'h0; v.cons = k;
    v.en = en; v.addr = addr; v.qc = qc; v.qd = qd; v.hip = hip; v.err = err;
    vecs.push_back(v);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    flush    = 1'b0;
    flush_cs = 16'h0;
    flush_ip = 16'h0;
    consume  = 2'd0;
    rom_data = 8'h00;

    //  rst cons en  addr      qc qd        hip       err
    add(1, 0, 0, 20'hFFFF0, 0, 16'h0000, 16'h0000, 0);
    add(0, 0, 1, 20'hFFFF0, 0, 16'h0000, 16'h0000, 0);
    add(0, 0, 1, 20'hFFFF1, 0, 16'h0000, 16'h0000, 0);
    add(0, 0, 1, 20'hFFFF2, 1, 16'h00F0, 16'h0000, 0);
    add(0, 0, 1, 20'hFFFF3, 2, 16'hF1F0, 16'h0000, 0);
    add(0, 0, 1, 20'hFFFF4, 3, 16'hF1F0, 16'h0000, 0);
    add(0, 0, 1, 20'hFFFF5, 4, 16'hF1F0, 16'h0000, 0);
    add(0, 0, 0, 20'hFFFF6, 5, 16'hF1F0, 16'h0000, 0);
    add(0, 0, 0, 20'hFFFF6, 6, 16'hF1F0, 16'h0000, 0);
    add(0, 2, 0, 20'hFFFF6, 6, 16'hF1F0, 16'h0000, 0);
    add(0, 2, 1, 20'hFFFF6, 4, 16'hF3F2, 16'h0002, 0);
    add(0, 2, 1, 20'hFFFF7, 2, 16'hF5F4, 16'h0004, 0);
    add(0, 2, 1, 20'hFFFF8, 1, 16'h00F6, 16'h0006, 0);
    add(0, 0, 1, 20'hFFFF9, 2, 16'hF7F6, 16'h0006, 1);
    add(0, 1, 1, 20'hFFFFA, 3, 16'hF7F6, 16'h0006, 0);
    add(0, 3, 1, 20'hFFFFB, 3, 16'hF8F7, 16'h0007, 0);
    add(0, 0, 1, 20'hFFFFC, 4, 16'hF8F7, 16'h0007, 0);
    add(0, 0, 0, 20'hFFFFD, 5, 16'hF8F7, 16'h0007, 0);
    add(0, 2, 0, 20'hFFFFD, 6, 16'hF8F7, 16'h0007, 0);
    add(0, 0, 1, 20'hFFFFD, 4, 16'hFAF9, 16'h0009, 0);
    add(0, 2, 1, 20'hFFFFE, 4, 16'hFAF9, 16'h0009, 0);

    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].rst, vecs[i].flush, vecs[i].fcs, vecs[i].fip, vecs[i].cons);
      check($sformatf("row%0d rom_en", i),      20'(rom_en),      20'(vecs[i].en));
      check($sformatf("row%0d rom_addr", i),    rom_addr,         vecs[i].addr);
      check($sformatf("row%0d q_count", i),     20'(q_count),     20'(vecs[i].qc));
      check($sformatf("row%0d q_data", i),      20'(q_data),      20'(vecs[i].qd));
      check($sformatf("row%0d head_ip", i),     20'(head_ip),     20'(vecs[i].hip));
      check($sformatf("row%0d consume_err", i), 20'(consume_err), 20'(vecs[i].err));
    end

    // Flush with a fetch in flight and a legal consume in the same cycle.
    cyc(0, 1, 16'h1234, 16'h0010, 2'd1);
    check("flush rom_en", 20'(rom_en), 20'd0);
    cyc(0, 0, 16'h0, 16'h0, 2'd0);
    check("flush+1 rom_en", 20'(rom_en), 20'd1);
    check("flush+1 rom_addr", rom_addr, 20'h12350);
    check("flush+1 q_count", 20'(q_count), 20'd0);
    check("flush+1 head_ip", 20'(head_ip), 20'h00010);
    check("flush+1 consume_err", 20'(consume_err), 20'd0);
    cyc(0, 0, 16'h0, 16'h0, 2'd0);
    check("flush+2 rom_addr", rom_addr, 20'h12351);
    check("flush+2 q_count", 20'(q_count), 20'd0);
    // Illegal consume of 2 with one byte queued.
    cyc(0, 0, 16'h0, 16'h0, 2'd2);
    check("flush+3 q_count", 20'(q_count), 20'd1);
    check("flush+3 q_data", 20'(q_data), 20'h00050);
    check("flush+3 consume_err", 20'(consume_err), 20'd0);
    cyc(0, 0, 16'h0, 16'h0, 2'd0);
    check("badcons consume_err", 20'(consume_err), 20'd1);
    check("badcons q_data", 20'(q_data), 20'h05150);
    check("badcons head_ip", 20'(head_ip), 20'h00010);
    check("badcons q_count", 20'(q_count), 20'd2);
    cyc(0, 0, 16'h0, 16'h0, 2'd0);
    check("badcons+1 consume_err", 20'(consume_err), 20'd0);
    check("badcons+1 q_count", 20'(q_count), 20'd3);

    // Segment wrap of the fetch and head instruction pointers.
    cyc(0, 1, 16'h0000, 16'hFFFE, 2'd0);
    check("wrap flush rom_en", 20'(rom_en), 20'd0);
    cyc(0, 0, 16'h0, 16'h0, 2'd0);
    check("wrap addr0", rom_addr, 20'h0FFFE);
    check("wrap head_ip0", 20'(head_ip), 20'h0FFFE);
    cyc(0, 0, 16'h0, 16'h0, 2'd0);
    check("wrap addr1", rom_addr, 20'h0FFFF);
    cyc(0, 0, 16'h0, 16'h0, 2'd1);
    check("wrap addr2", rom_addr, 20'h00000);
    check("wrap q_data0", 20'(q_data), 20'h000FE);
    cyc(0, 0, 16'h0, 16'h0, 2'd1);
    check("wrap addr3", rom_addr, 20'h00001);
    check("wrap q_data1", 20'(q_data), 20'h000FF);
    check("wrap head_ip1", 20'(head_ip), 20'h0FFFF);

    // Flush together with a consume that would otherwise be illegal.
    cyc(0, 1, 16'h2000, 16'h0142, 2'd2);
    check("wrap head_ip2", 20'(head_ip), 20'h00000);
    check("wrap q_count", 20'(q_count), 20'd1);
    check("flushcons rom_en", 20'(rom_en), 20'd0);
    cyc(0, 0, 16'h0, 16'h0, 2'd0);
    check("flushcons consume_err", 20'(consume_err), 20'd0);
    check("flushcons q_count", 20'(q_count), 20'd0);
    check("flushcons rom_addr", rom_addr, 20'h20142);
    check("flushcons head_ip", 20'(head_ip), 20'h00142);
    cyc(0, 0, 16'h0, 16'h0, 2'd0);
    check("flushcons+1 rom_addr", rom_addr, 20'h20143);

    // Reset asserted while bytes are arriving.
    cyc(1, 0, 16'h0, 16'h0, 2'd0);
    check("midrst q_data", 20'(q_data), 20'h00042);
    check("midrst rom_en", 20'(rom_en), 20'd0);
    cyc(1, 0, 16'h0, 16'h0, 2'd1);
    check("rst q_count", 20'(q_count), 20'd0);
    check("rst q_data", 20'(q_data), 20'd0);
    check("rst rom_en", 20'(rom_en), 20'd0);
    check("rst head_ip", 20'(head_ip), 20'd0);
    check("rst consume_err", 20'(consume_err), 20'd0);
    check("rst rom_addr", rom_addr, 20'hFFFF0);
    cyc(0, 0, 16'h0, 16'h0, 2'd0);
    check("postrst rom_en", 20'(rom_en), 20'd1);
    check("postrst rom_addr", rom_addr, 20'hFFFF0);
    cyc(0, 0, 16'h0, 16'h0, 2'd0);
    check("postrst+1 rom_addr", rom_addr, 20'hFFFF1);
    check("postrst+1 q_count", 20'(q_count), 20'd0);
    cyc(0, 0, 16'h0, 16'h0, 2'd0);
    check("postrst+2 q_count", 20'(q_count), 20'd1);
    check("postrst+2 q_data", 20'(q_data), 20'h000F0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
